// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider producing quotient (lo) and remainder (hi).
// Define DIV_BYZERO_FAST_EN to resolve a zero divisor in IDLE without iterating.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             annul,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] rem, quo, dvsr;
   logic [CW-1:0]    cnt;
   logic             neg_rem, neg_quo;
   logic             accept, fast_zero;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             fits;

   assign accept = start & ~annul & (state == IDLE);
   assign a_abs  = (signed_div && a[WIDTH-1]) ? -a : a;
   assign b_abs  = (signed_div && b[WIDTH-1]) ? -b : b;

   // Partial remainder stays below the divisor, so the subtraction fits in WIDTH bits.
   assign rem_sh  = {rem, quo[WIDTH-1]};
   assign fits    = (rem_sh >= {1'b0, dvsr});
   assign rem_sub = rem_sh[WIDTH-1:0] - dvsr;

`ifdef DIV_BYZERO_FAST_EN
   logic [WIDTH-1:0] zero_lo;
   assign fast_zero = (b == '0);
   assign zero_lo   = (signed_div && a[WIDTH-1]) ? WIDTH'(1) : '1;
`else
   assign fast_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = fast_zero ? DONE : CALC;
         CALC: begin
            if (annul)                         state_nxt = IDLE;
            else if (cnt == CW'(WIDTH - 1))    state_nxt = FIX;
         end
         FIX:  state_nxt = annul ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == CALC) || (state == FIX);
      done      = (state == DONE);
      stall_req = busy | accept;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         cnt     <= '0;
         neg_rem <= 1'b0;
         neg_quo <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               rem     <= '0;
               quo     <= a_abs;
               dvsr    <= b_abs;
               cnt     <= '0;
               neg_rem <= signed_div & a[WIDTH-1];
               neg_quo <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef DIV_BYZERO_FAST_EN
               if (fast_zero) begin
                  hi <= a;
                  lo <= zero_lo;
               end
`endif
            end
            CALC: begin
               rem <= fits ? rem_sub : rem_sh[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], fits};
               cnt <= cnt + 1'b1;
            end
            FIX: if (!annul) begin
               lo <= neg_quo ? -quo : quo;
               hi <= neg_rem ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against a cycle-level behavioural model.
module tb_div_iter;

`ifdef DIV_BYZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, sg, annul;
   logic [31:0] a, b;
   logic        busy, stall_req, done;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   div_iter #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .signed_div(sg),
      .a(a), .b(b), .annul(annul), .busy(busy), .stall_req(stall_req),
      .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {hi, lo} from plain integer division.
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint sx, sy, q, r;
      if (y == 32'd0) return {x, (s && x[31]) ? 32'd1 : 32'hFFFF_FFFF};
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = {32'd0, x};
         sy = {32'd0, y};
      end
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   // Model: ph is the cycle index relative to the accepting cycle T (0 = idle, 34 = done cycle).
   int          ph;
   logic [31:0] p_hi, p_lo, m_hi, m_lo;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ph = 0; m_hi = '0; m_lo = '0;
      end else if (ph == 0) begin
         if (start && !annul) begin
            {p_hi, p_lo} = ref_div(a, b, sg);
            if (FAST && b == 32'd0) begin
               ph = 34; m_hi = p_hi; m_lo = p_lo;
            end else ph = 1;
         end
      end else if (ph <= 33) begin
         if (annul) ph = 0;
         else begin
            ph++;
            if (ph == 34) begin m_hi = p_hi; m_lo = p_lo; end
         end
      end else ph = 0;
   end

   always @(negedge clk) begin
      if (resetn) begin
         chk("busy", busy, (ph >= 1 && ph <= 33));
         chk("done", done, (ph == 34));
         chk("stall_req", stall_req, (ph >= 1 && ph <= 33) || (ph == 0 && start && !annul));
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Caller is positioned in cycle T; returns positioned in cycle T+35.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] elo, input logic [31:0] ehi, input int lat, input int poke);
      int cyc, bc;
      a = x; b = y; sg = s; start = 1'b1;
      step(); start = 1'b0;
      cyc = 1; bc = 0;
      while (!done && cyc < 100) begin
         if (busy) bc++;
         if (cyc == poke) begin start = 1'b1; a = 32'd77; b = 32'd1; end
         step(); start = 1'b0;
         cyc++;
      end
      chk("latency", cyc, lat);
      chk("busy_cycles", bc, lat - 1);
      chk("op_lo", lo, elo);
      chk("op_hi", hi, ehi);
      step();
   endtask

   initial begin
      logic [63:0] r;
      int          seen, ak, cyc;
      bit          aborted;

      resetn = 1'b0; start = 1'b0; sg = 1'b0; annul = 1'b0; a = '0; b = '0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      resetn = 1'b1;
      step();

      r = ref_div(32'd100, 32'd7, 1'b0);
      chk("model_u_lo", r[31:0], 32'd14);  chk("model_u_hi", r[63:32], 32'd2);
      r = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("model_s_lo", r[31:0], 32'hFFFF_FFFD);  chk("model_s_hi", r[63:32], 32'hFFFF_FFFF);
      r = ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("model_ovf_lo", r[31:0], 32'h8000_0000);  chk("model_ovf_hi", r[63:32], 32'd0);
      r = ref_div(32'hFFFF_FFFB, 32'd0, 1'b1);
      chk("model_z_lo", r[31:0], 32'd1);  chk("model_z_hi", r[63:32], 32'hFFFF_FFFB);

      do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 0);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 34, 0);
      do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB, FAST ? 1 : 34, 0);
      do_op(32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd9, FAST ? 1 : 34, 0);

      // Flush in T+10: no done, results untouched.
      a = 32'd50; b = 32'd5; sg = 1'b0; start = 1'b1;
      step(); start = 1'b0;
      repeat (9) step();
      annul = 1'b1;
      step(); annul = 1'b0;
      chk("annul_busy", busy, 0);
      seen = 0;
      repeat (40) begin if (done) seen = 1; step(); end
      chk("annul_no_done", seen, 0);
      chk("annul_lo", lo, 32'hFFFF_FFFF);
      chk("annul_hi", hi, 32'd9);

      // start with annul together is dropped.
      a = 32'd20; b = 32'd4; start = 1'b1; annul = 1'b1;
      step(); start = 1'b0; annul = 1'b0;
      chk("start_annul_busy", busy, 0);
      step();

      do_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 34, 5);

      // Asynchronous reset in the middle of an operation.
      a = 32'd12345; b = 32'd7; sg = 1'b0; start = 1'b1;
      step(); start = 1'b0;
      repeat (19) step();
      resetn = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      step();
      resetn = 1'b1;
      step();
      do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 0);

      for (int n = 0; n < 60; n++) begin
         int gap, sel;
         gap = $urandom_range(0, 2);
         repeat (gap) step();
         sg = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFF_FFFF;
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
         aborted = (ak >= 1 && ak <= 33 && !(FAST && b == 32'd0));
         start = 1'b1;
         step(); start = 1'b0;
         cyc = 1;
         while (!done && cyc < 60) begin
            if (cyc == ak) annul = 1'b1;
            step(); annul = 1'b0;
            cyc++;
         end
         chk("rand_done_or_abort", done ? 0 : 1, aborted);
         step();
      end

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
